// File: rtl/layer_sequencer_if.sv
// Control bundle between the host, the layer sequencer and the per-layer
// conv controllers. The slave side is the sequencer itself; the master side
// is whoever drives run/abort and returns the layer_done handshakes.
interface layer_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int LW         = 2,
  parameter int OC_W       = 4
);
  logic                  run;
  logic                  abort;
  logic [NUM_LAYERS-1:0] layer_done;
  logic [NUM_LAYERS-1:0] layer_start;
  logic [LW-1:0]         layer_idx;
  logic [OC_W-1:0]       oc_idx;
  logic                  busy;
  logic                  net_done;
  logic                  timeout;

  modport master (
    output run, abort, layer_done,
    input  layer_start, layer_idx, oc_idx, busy, net_done, timeout
  );

  modport slave (
    input  run, abort, layer_done,
    output layer_start, layer_idx, oc_idx, busy, net_done, timeout
  );
endinterface

// File: rtl/layer_sequencer.sv
// Network-level scheduler: walks layers 0..NUM_LAYERS-1, pulses one start per
// output channel of the current layer and waits for that layer's done before
// moving on. Zero-channel layers are skipped; a per-channel watchdog or an
// external abort drops the walk back to IDLE.
module layer_sequencer #(
  parameter int                         NUM_LAYERS = 3,
  parameter int                         LW         = 2,
  parameter int                         OC_W       = 4,
  parameter logic [NUM_LAYERS*OC_W-1:0] LAYER_OC   = {4'd2, 4'd0, 4'd3},
  parameter int                         TO_W       = 16,
  parameter int                         TIMEOUT    = 1024
) (
  input logic              clk,
  input logic              rst,
  layer_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_DONE
  } state_t;

  localparam logic [LW-1:0]   LAST_L = LW'(NUM_LAYERS - 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT - 1);

  state_t          state, state_d;
  logic [LW-1:0]   lidx, lidx_d;
  logic [OC_W-1:0] oc, oc_d;
  logic [TO_W-1:0] wd, wd_d;
  logic            to_flag, to_d;

  logic [OC_W-1:0] cnt;
  logic [OC_W-1:0] oc_inc;
  logic            cur_done;

  // Channel count and done bit of the layer currently being worked on; done
  // bits of every other layer are masked out here.
  always_comb begin
    cnt      = '0;
    cur_done = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (lidx == LW'(i)) begin
        cnt      = LAYER_OC[i*OC_W +: OC_W];
        cur_done = bus.layer_done[i];
      end
    end
  end

  // oc never exceeds cnt-1, so this increment cannot wrap in practice.
  assign oc_inc = oc + OC_W'(1);

  // Next-state and next-index logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state;
    lidx_d  = lidx;
    oc_d    = oc;
    wd_d    = wd;
    to_d    = to_flag;
    case (state)
      S_IDLE: begin
        if (bus.run && !bus.abort) begin
          lidx_d  = '0;
          oc_d    = '0;
          to_d    = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt == '0) begin
          state_d = S_ADV;
        end else begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cur_done) begin
          state_d = S_ADV;
        end else if (TIMEOUT != 0 && wd == TO_LIM) begin
          to_d    = 1'b1;
          lidx_d  = '0;
          oc_d    = '0;
          state_d = S_IDLE;
        end else if (wd != '1) begin
          // saturating count; only matters with the watchdog disabled
          wd_d = wd + TO_W'(1);
        end
      end
      S_ADV: begin
        if (cnt != '0 && oc_inc < cnt) begin
          oc_d    = oc_inc;
          state_d = S_ISSUE;
        end else begin
          oc_d = '0;
          if (lidx == LAST_L) begin
            state_d = S_DONE;
          end else begin
            lidx_d  = lidx + LW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        lidx_d  = '0;
        oc_d    = '0;
        state_d = S_IDLE;
      end
      default: begin
        lidx_d  = '0;
        oc_d    = '0;
        state_d = S_IDLE;
      end
    endcase
    // abort wins over done, watchdog and advance, and never sets timeout
    if (bus.abort && state != S_IDLE) begin
      state_d = S_IDLE;
      lidx_d  = '0;
      oc_d    = '0;
      wd_d    = wd;
      to_d    = to_flag;
    end
  end

  // State, indices, watchdog and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      lidx    <= '0;
      oc      <= '0;
      wd      <= '0;
      to_flag <= 1'b0;
    end else begin
      state   <= state_d;
      lidx    <= lidx_d;
      oc      <= oc_d;
      wd      <= wd_d;
      to_flag <= to_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output
  // combinationally.
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_start
    assign bus.layer_start[i] = (state == S_ISSUE) && (cnt != '0) && (lidx == LW'(i));
  end

  assign bus.layer_idx = lidx;
  assign bus.oc_idx    = oc;
  assign bus.busy      = (state != S_IDLE);
  assign bus.net_done  = (state == S_DONE);
  assign bus.timeout   = to_flag;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: one instance with the default layer
// table and one with every layer configured to zero channels.
module tb_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_z = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   nd_cnt = 0;
  int   nd_snap;

  always #5 clk = ~clk;

  layer_sequencer_if #(.NUM_LAYERS(3), .LW(2), .OC_W(4)) bus ();
  layer_sequencer_if #(.NUM_LAYERS(3), .LW(2), .OC_W(4)) bus_z ();

  layer_sequencer #(
    .NUM_LAYERS(3), .LW(2), .OC_W(4), .LAYER_OC({4'd2, 4'd0, 4'd3}),
    .TO_W(16), .TIMEOUT(1024)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  layer_sequencer #(
    .NUM_LAYERS(3), .LW(2), .OC_W(4), .LAYER_OC(12'h000),
    .TO_W(16), .TIMEOUT(1024)
  ) dut_z (
    .clk(clk), .rst(rst_z), .bus(bus_z.slave)
  );

  // count net_done pulses of the main instance
  always @(posedge clk) if (bus.net_done) nd_cnt <= nd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called on the ISSUE cycle of a channel; returns on the next ISSUE/DONE cycle.
  // layer_done is returned two cycles after the start pulse.
  task automatic chan(input int l, input int o);
    chk("start", bus.layer_start, 32'(1 << l));
    chk("lidx", bus.layer_idx, 32'(l));
    chk("oc", bus.oc_idx, 32'(o));
    chk("busy", bus.busy, 1);
    step();
    chk("wait1_start", bus.layer_start, 0);
    chk("wait1_oc", bus.oc_idx, 32'(o));
    step();
    chk("wait2_busy", bus.busy, 1);
    chk("wait2_start", bus.layer_start, 0);
    bus.layer_done = 3'(1 << l);
    step();
    bus.layer_done = '0;
    chk("adv_start", bus.layer_start, 0);
    chk("adv_oc", bus.oc_idx, 32'(o));
    step();
  endtask

  // Called on the ISSUE cycle of the empty layer 1.
  task automatic skip1();
    chk("skip_start", bus.layer_start, 0);
    chk("skip_lidx", bus.layer_idx, 1);
    chk("skip_busy", bus.busy, 1);
    step();
    chk("skip_adv_start", bus.layer_start, 0);
    chk("skip_adv_lidx", bus.layer_idx, 1);
    step();
  endtask

  // Pulses run and lands on the first ISSUE cycle.
  task automatic kick();
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
  endtask

  initial begin
    bus.run = 0; bus.abort = 0; bus.layer_done = '0;
    bus_z.run = 0; bus_z.abort = 0; bus_z.layer_done = '0;
    #12;
    // reset values
    chk("rst_start", bus.layer_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_idx", {bus.layer_idx, bus.oc_idx}, 0);
    chk("rst_nd_to", {bus.net_done, bus.timeout}, 0);
    chk("rst_z_busy", bus_z.busy, 0);
    step();
    rst = 1'b0; rst_z = 1'b0;
    step();

    // full walk: 3 channels on layer0, layer1 skipped, 2 channels on layer2
    nd_snap = nd_cnt;
    kick();
    chan(0, 0); chan(0, 1); chan(0, 2);
    skip1();
    chan(2, 0); chan(2, 1);
    chk("done_nd", bus.net_done, 1);
    chk("done_busy", bus.busy, 1);
    step();
    chk("idle_busy", bus.busy, 0);
    chk("idle_nd", bus.net_done, 0);
    chk("idle_idx", {bus.layer_idx, bus.oc_idx}, 0);
    chk("nd_once", nd_cnt, nd_snap + 1);

    // done in the ISSUE cycle is ignored, watchdog fires after 1024 WAIT cycles
    nd_snap = nd_cnt;
    kick();
    chk("to_issue", bus.layer_start, 1);
    bus.layer_done = 3'b001;
    step();
    bus.layer_done = '0;
    chk("to_w1_oc", bus.oc_idx, 0);
    for (int i = 0; i < 1023; i++) step();
    chk("to_pre_busy", bus.busy, 1);
    chk("to_pre_flag", bus.timeout, 0);
    step();
    chk("to_busy", bus.busy, 0);
    chk("to_flag", bus.timeout, 1);
    chk("to_no_nd", nd_cnt, nd_snap);
    step();
    chk("to_sticky", bus.timeout, 1);

    // foreign done ignored; own done advances; then abort on layer2/oc1
    kick();
    chk("rerun_to_clr", bus.timeout, 0);
    step();
    bus.layer_done = 3'b100;
    step();
    chk("foreign_oc", bus.oc_idx, 0);
    chk("foreign_busy", bus.busy, 1);
    chk("foreign_start", bus.layer_start, 0);
    bus.layer_done = 3'b001;
    step();
    bus.layer_done = '0;
    step();
    chan(0, 1); chan(0, 2);
    skip1();
    chan(2, 0);
    nd_snap = nd_cnt;
    chk("ab_issue", bus.layer_start, 3'b100);
    step();
    bus.abort = 1'b1; bus.layer_done = 3'b100;
    step();
    bus.abort = 1'b0; bus.layer_done = '0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_idx", {bus.layer_idx, bus.oc_idx}, 0);
    chk("ab_to", bus.timeout, 0);
    chk("ab_nd", nd_cnt, nd_snap);
    step();
    chk("ab_stay_idle", bus.busy, 0);

    // run held high across the whole walk: busy run ignored, restart after IDLE
    bus.run = 1'b1;
    step();
    chan(0, 0); chan(0, 1); chan(0, 2);
    skip1();
    chan(2, 0); chan(2, 1);
    chk("hold_done", bus.net_done, 1);
    step();
    chk("hold_idle", bus.busy, 0);
    step();
    bus.run = 1'b0;
    chk("hold_restart", bus.layer_start, 1);
    chk("hold_restart_idx", {bus.layer_idx, bus.oc_idx}, 0);
    bus.abort = 1'b1;
    step();
    chk("ab_issue_busy", bus.busy, 0);
    // abort together with run in IDLE: run ignored
    bus.run = 1'b1;
    step();
    bus.run = 1'b0; bus.abort = 1'b0;
    chk("ab_run_idle", bus.busy, 0);
    step();
    chk("ab_run_idle2", bus.busy, 0);

    // all layers empty: no starts, net_done 7 cycles after run is sampled
    bus_z.run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      bus_z.run = 1'b0;
      chk("z_start", bus_z.layer_start, 0);
      chk("z_nd", bus_z.net_done, (i == 7) ? 1 : 0);
      chk("z_busy", bus_z.busy, (i <= 7) ? 1 : 0);
    end

    // asynchronous reset mid-WAIT on layer2/oc1
    kick();
    chan(0, 0); chan(0, 1); chan(0, 2);
    skip1();
    chan(2, 0);
    step();
    chk("pre_rst_oc", bus.oc_idx, 1);
    chk("pre_rst_lidx", bus.layer_idx, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_idx", {bus.layer_idx, bus.oc_idx}, 0);
    chk("mid_rst_start", bus.layer_start, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Network-level scheduler above the per-layer controllers.
- On a run pulse it walks layers 0..NUM_LAYERS-1 in order. For each layer it issues one start pulse per output channel and waits for that layer's done before issuing the next.
- Tracks the current layer/output-channel indices, skips layers configured with zero channels, and aborts on a watchdog timeout or an external abort.
- Sits between the host/top-level control and the layer_start/layer_done handshakes of the conv layer controllers.

Parameters:
- NUM_LAYERS, 3, number of sequenced layers (1..8).
- LW, 2, width of layer_idx; must satisfy 2**LW >= NUM_LAYERS.
- OC_W, 4, width of the per-layer output-channel count and of oc_idx.
- LAYER_OC, {4'd2,4'd0,4'd3}, packed channel counts. Layer i count is LAYER_OC[i*OC_W +: OC_W]. The default gives layer0=3, layer1=0, layer2=2. A count of 0 skips the layer.
- TO_W, 16, watchdog counter width.
- TIMEOUT, 1024, max WAIT cycles per channel before abort; 0 disables the watchdog.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- run, input, 1, start-network request; sampled only in IDLE.
- abort, input, 1, synchronous abort; returns the block to IDLE.
- layer_done, input, NUM_LAYERS, per-layer done; bit i is honoured only while waiting on layer i.
- layer_start, output, NUM_LAYERS, one-hot single-cycle start pulse to layer i.
- layer_idx, output, LW, current layer index.
- oc_idx, output, OC_W, current output-channel index within the layer.
- busy, output, 1, high in every state except IDLE.
- net_done, output, 1, single-cycle pulse when all layers have completed.
- timeout, output, 1, sticky watchdog-abort flag.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - layer_start=0, layer_idx=0, oc_idx=0, busy=0, net_done=0, timeout=0.
  - Watchdog counter=0.
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE. All outputs are derived from registered state/indices; there are no combinational paths from inputs to outputs.
- IDLE:
  - If run=1: layer_idx<=0, oc_idx<=0, timeout<=0, go to ISSUE.
  - run is otherwise ignored.
- ISSUE (one cycle):
  - If count(layer_idx)==0: no pulse, go to ADVANCE.
  - Else: layer_start[layer_idx]=1 for this cycle only, watchdog<=0, go to WAIT.
  - layer_done is ignored in ISSUE.
  - Latency: run sampled at edge k gives layer_start high in cycle k+1.
- WAIT:
  - If layer_done[layer_idx]=1: go to ADVANCE.
  - Else, if TIMEOUT!=0 and watchdog==TIMEOUT-1: timeout<=1, go to IDLE.
  - Else: watchdog++.
  - Done bits for other layers are ignored.
  - If done and the timeout threshold coincide, done wins.
- ADVANCE (one cycle):
  - If count!=0 and oc_idx+1 < count: oc_idx++, go to ISSUE.
  - Else: oc_idx<=0. If layer_idx==NUM_LAYERS-1, go to DONE; else layer_idx++ and go to ISSUE.
- DONE (one cycle):
  - net_done=1, then go to IDLE.
  - layer_idx/oc_idx are cleared to 0 on entry to IDLE.
- Channel cadence: minimum 3 cycles per channel (ISSUE, WAIT, ADVANCE) when done returns in the first WAIT cycle. A skipped layer costs 2 cycles.
- abort:
  - In any state except IDLE: next state is IDLE, indices are cleared, and no net_done is issued.
  - abort has priority over layer_done, timeout and state advance. It does not set timeout.
  - abort in IDLE has no effect, and abort and run together in IDLE means run is ignored.
- timeout remains set through IDLE until the next accepted run.
- Arithmetic:
  - Index compares are unsigned at OC_W width.
  - oc_idx never exceeds count-1, so no wrap occurs.
  - The watchdog saturates at the threshold and never wraps.
- Reset mid-operation: asynchronous return to the reset values. Any in-flight layer is not signalled; the layers are reset by the same rst.

Test Plan:
- Default params, run pulse, each layer_done returned 2 cycles after its start:
  - layer_start[0] pulses 3 times with oc_idx 0,1,2.
  - Layer1 is skipped with no pulse.
  - layer_start[2] pulses twice with oc_idx 0,1.
  - Then net_done pulses once and busy falls the next cycle.
- Done returned in the same cycle as ISSUE, then not again: no advance; watchdog fires after 1024 WAIT cycles, timeout=1, busy=0, no net_done.
- layer_done[2] asserted while waiting on layer0: ignored, oc_idx stays 0. layer_done[0] then advances to oc_idx=1.
- abort during WAIT on layer2/oc1 together with layer_done[2]: next cycle IDLE, indices 0, no net_done, timeout=0.
- run held high across DONE: a new sequence starts from layer0/oc0 on the cycle after returning to IDLE. A second run while busy is ignored.
- LAYER_OC all zeros: run leads to no layer_start; net_done occurs 2*NUM_LAYERS+1 cycles after run is sampled. rst asserted mid-WAIT clears all outputs immediately.
